// File: rtl/rhythm_pkg.sv
// Shared constants and state encoding for the rhythm game scoring blocks.
package rhythm_pkg;

    localparam int unsigned SCORE_W = 5;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 5'd31;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_NOTE = 2'd1,
        WINDOW    = 2'd2,
        DONE      = 2'd3
    } state_e;

endpackage

// File: rtl/btn_edge.sv
// Registers the synchronised button and flags its rising edge as a press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/score_keeper.sv
// Per-player hit judge: opens a timed window per note, judges hit/miss and
// accumulates a saturating score over a fixed number of notes.
module score_keeper
    import rhythm_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES   = 8,
    parameter int unsigned NOTES_PER_ROUND = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               note_strobe,
    input  logic               btn,
    output logic [SCORE_W-1:0] result,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               busy,
    output logic               round_done
);

    localparam int unsigned WIN_W  = $clog2(WINDOW_CYCLES + 1);
    localparam int unsigned NOTE_W = $clog2(NOTES_PER_ROUND + 1);

    localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(1);
    localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(NOTES_PER_ROUND - 1);

    state_e              state_q, state_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [NOTE_W-1:0]   note_cnt_q, note_cnt_d;
    logic                hit_q, hit_d;
    logic                miss_q, miss_d;
    logic                press;
    logic                judged;

    btn_edge u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press)
    );

    // A new strobe closes the open note just like window expiry does.
    assign judged = press | note_strobe | (win_cnt_q == WIN_LAST);

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        win_cnt_d  = win_cnt_q;
        note_cnt_d = note_cnt_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    score_d    = '0;
                    note_cnt_d = '0;
                    state_d    = WAIT_NOTE;
                end
            end
            WAIT_NOTE: begin
                if (note_strobe) begin
                    win_cnt_d = WIN_LOAD;
                    state_d   = WINDOW;
                end
            end
            WINDOW: begin
                if (press) begin
                    hit_d = 1'b1;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + 1'b1;
                    end
                end else if (judged) begin
                    miss_d = 1'b1;
                end

                if (judged) begin
                    note_cnt_d = note_cnt_q + 1'b1;
                    if (note_cnt_q == NOTE_LAST) begin
                        state_d = DONE;
                    end else if (note_strobe) begin
                        win_cnt_d = WIN_LOAD;
                    end else begin
                        state_d = WAIT_NOTE;
                    end
                end else begin
                    win_cnt_d = win_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            score_q    <= '0;
            win_cnt_q  <= '0;
            note_cnt_q <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            win_cnt_q  <= win_cnt_d;
            note_cnt_q <= note_cnt_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign result     = score_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign busy       = (state_q == WAIT_NOTE) || (state_q == WINDOW);
    assign round_done = (state_q == DONE);

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a 4-note instance for judging behaviour and
// a 31-note instance for score saturation.
module tb_score_keeper;

    logic       clk;
    logic       reset;
    logic       start;
    logic       note_strobe;
    logic       btn;

    logic [4:0] res_a, res_b;
    logic       hit_a, miss_a, busy_a, done_a;
    logic       hit_b, miss_b, busy_b, done_b;

    int checks;
    int failures;
    int hits_a, misses_a, both_cnt;
    logic clr_cnt;

    score_keeper #(.WINDOW_CYCLES(8), .NOTES_PER_ROUND(4)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .note_strobe (note_strobe),
        .btn         (btn),
        .result      (res_a),
        .hit_pulse   (hit_a),
        .miss_pulse  (miss_a),
        .busy        (busy_a),
        .round_done  (done_a)
    );

    score_keeper #(.WINDOW_CYCLES(8), .NOTES_PER_ROUND(31)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .note_strobe (note_strobe),
        .btn         (btn),
        .result      (res_b),
        .hit_pulse   (hit_b),
        .miss_pulse  (miss_b),
        .busy        (busy_b),
        .round_done  (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies for instance A, sampled mid-cycle.
    always @(negedge clk) begin
        if (clr_cnt) begin
            hits_a   <= 0;
            misses_a <= 0;
        end else begin
            hits_a   <= hits_a + int'(hit_a);
            misses_a <= misses_a + int'(miss_a);
        end
        if ((hit_a && miss_a) || (hit_b && miss_b)) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic start_round();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic note();
        note_strobe = 1'b1;
        tick();
        note_strobe = 1'b0;
    endtask

    task automatic press();
        btn = 1'b1;
        tick();
        btn = 1'b0;
    endtask

    task automatic clear_counts();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        both_cnt    = 0;
        hits_a      = 0;
        misses_a    = 0;
        clr_cnt     = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        note_strobe = 1'b0;
        btn         = 1'b0;

        // Reset state
        do_reset();
        check("rst_result", res_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_hit", hit_a, 0);
        check("rst_miss", miss_a, 0);

        // Reset mid-round after three hits
        start_round();
        check("start_busy", busy_a, 1);
        for (int i = 0; i < 3; i++) begin
            note();
            press();
            check("mid_hit", hit_a, 1);
        end
        check("mid_score3", res_a, 3);
        do_reset();
        check("mid_rst_result", res_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_hit", hit_a, 0);
        check("mid_rst_miss", miss_a, 0);

        // Basic round: hits at T+1 and T+8, then two misses
        clear_counts();
        start_round();
        note();
        press();
        check("basic_hit_t1", hit_a, 1);
        note();
        idle(7);
        press();
        check("basic_hit_t8", hit_a, 1);
        note();
        idle(7);
        check("basic_nomiss_t7", miss_a, 0);
        idle(1);
        check("basic_miss3", miss_a, 1);
        check("basic_busy_mid", busy_a, 1);
        note();
        idle(8);
        check("basic_miss4", miss_a, 1);
        check("basic_done", done_a, 1);
        check("basic_busy_end", busy_a, 0);
        idle(1);
        check("basic_hits", hits_a, 2);
        check("basic_misses", misses_a, 2);
        check("basic_score", res_a, 2);

        // Window edges
        do_reset();
        clear_counts();
        start_round();
        note_strobe = 1'b1;
        btn = 1'b1;
        tick();
        note_strobe = 1'b0;
        btn = 1'b0;
        idle(7);
        check("edge_t_nomiss_early", miss_a, 0);
        idle(1);
        check("edge_t_miss", miss_a, 1);
        idle(1);
        check("edge_t_nohits", hits_a, 0);
        note();
        idle(8);
        check("edge_t9_miss", miss_a, 1);
        press();
        check("edge_t9_nohit", hit_a, 0);
        check("edge_t9_score", res_a, 0);
        note();
        btn = 1'b1;
        tick();
        check("held_first_hit", hit_a, 1);
        note();
        idle(8);
        check("held_second_miss", miss_a, 1);
        check("held_done", done_a, 1);
        check("held_score", res_a, 1);
        btn = 1'b0;

        // Overlapping notes
        do_reset();
        start_round();
        note();
        idle(2);
        note();
        check("ovl_miss_first", miss_a, 1);
        check("ovl_busy", busy_a, 1);
        idle(7);
        check("ovl_nomiss_t10", miss_a, 0);
        idle(1);
        check("ovl_miss_second", miss_a, 1);
        note();
        idle(2);
        note_strobe = 1'b1;
        btn = 1'b1;
        tick();
        note_strobe = 1'b0;
        btn = 1'b0;
        check("ovl_press_hit", hit_a, 1);
        check("ovl_press_nomiss", miss_a, 0);
        idle(8);
        check("ovl_press_second_miss", miss_a, 1);
        check("ovl_done", done_a, 1);
        check("ovl_score", res_a, 1);

        // Saturation on the 31-note instance
        do_reset();
        start_round();
        for (int i = 0; i < 31; i++) begin
            note();
            press();
        end
        check("sat1_score", res_b, 31);
        check("sat1_done", done_b, 1);
        start_round();
        check("sat2_cleared", res_b, 0);
        check("sat2_busy", busy_b, 1);
        check("sat2_done_clr", done_b, 0);
        for (int i = 0; i < 31; i++) begin
            note();
            press();
        end
        check("sat2_score", res_b, 31);
        check("sat2_done", done_b, 1);

        // Ignored inputs
        do_reset();
        press();
        check("ign_idle_press", hit_a, 0);
        check("ign_idle_busy", busy_a, 0);
        note();
        check("ign_idle_note", busy_a, 0);
        start_round();
        press();
        check("ign_wait_press", hit_a, 0);
        check("ign_wait_busy", busy_a, 1);
        note();
        start_round();
        check("ign_start_busy", busy_a, 1);
        press();
        check("ign_start_still_window", hit_a, 1);
        check("ign_start_score", res_a, 1);
        for (int i = 0; i < 3; i++) begin
            note();
            press();
        end
        check("ign_round_done", done_a, 1);
        check("ign_round_score", res_a, 4);
        clear_counts();
        press();
        note();
        idle(9);
        check("ign_done_hits", hits_a, 0);
        check("ign_done_misses", misses_a, 0);
        check("ign_done_score", res_a, 4);
        check("ign_done_level", done_a, 1);

        check("never_both_pulses", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
# score_keeper

Per-player hit judge and score accumulator for the rhythm game. For each note it opens a timed hit window and judges the player's button press as a hit or a miss. It accumulates a 5-bit score over a fixed-length round. Two instances, one per player, sit directly upstream of the `winner` comparator: their `result` outputs drive its `result1` and `result2` inputs, and `round_done` tells downstream logic the scores are final.

## Interface
- `WINDOW_CYCLES`, default 8: hit-window length in clock cycles; legal range 1..255.
- `NOTES_PER_ROUND`, default 20: notes judged per round; legal range 1..31.
- `clk` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled only on the `clk` rising edge; `reset`=0 forces the reset state.
- `start` in 1: single-cycle pulse; begins a new round.
- `note_strobe` in 1: single-cycle pulse; a note reaches the hit line.
- `btn` in 1: player button, already synchronised to `clk`, level, active-high.
- `result` out 5: current score, unsigned.
- `hit_pulse` out 1: one-cycle pulse per judged hit.
- `miss_pulse` out 1: one-cycle pulse per judged miss.
- `busy` out 1: high while a round is in progress.
- `round_done` out 1: level, high from round completion until the next `start`.

## Operation
- States:
  - IDLE: the reset state.
  - WAIT_NOTE: round active, no open window.
  - WINDOW: a note is awaiting judgement.
  - DONE: round finished.
- Press detection: `btn_q` is `btn` registered; a press is `btn`=1 and `btn_q`=0. A held button produces exactly one press.
- IDLE or DONE, `start`=1: clear `result` and the note counter, clear `round_done`, go to WAIT_NOTE. All other inputs are ignored in IDLE and DONE.
- WAIT_NOTE:
  - A press is ignored; no penalty.
  - `note_strobe` loads the window counter with `WINDOW_CYCLES`, then go to WINDOW.
- WINDOW, evaluated each cycle:
  - A press is a hit: `result` increments, saturating at 31. `hit_pulse` is asserted and the note counter increments.
  - Otherwise, if the window counter equals 1, it is a miss: `miss_pulse` is asserted and the note counter increments.
  - Otherwise the window counter decrements.
- After a hit or miss, go to DONE if the note counter reaches `NOTES_PER_ROUND`, else go to WAIT_NOTE.
- `note_strobe` while in WINDOW:
  - The open note is judged immediately: a hit if a press occurs in the same cycle, else a miss.
  - The window counter reloads for the new note and the state stays WINDOW, unless this judgement completes the round, in which case go to DONE.
- `start` while in WAIT_NOTE or WINDOW is ignored. A round can only be aborted by `reset`.
- `busy`=1 in WAIT_NOTE and WINDOW. `round_done`=1 in DONE.

## Timing
- Reset values: state IDLE; `result`=0; `btn_q`=0; both counters 0; `hit_pulse`, `miss_pulse`, `busy` and `round_done` all 0.
- Reset asserted mid-round takes effect at the next edge. The partial score is lost.
- `start` sampled at edge T: `busy`=1 and `result`=0 are visible after edge T.
- `note_strobe` sampled at edge T opens the window.
  - Presses sampled at edges T+1 through T+`WINDOW_CYCLES` inclusive are hits.
  - A press sampled at edge T itself is ignored.
  - With no press, `miss_pulse` is high in the cycle after edge T+`WINDOW_CYCLES`.
- Hit latency: a press sampled at edge P gives `hit_pulse`=1 and the incremented `result` in the cycle after P, i.e. a 1-cycle registered latency.
- `round_done` rises in the same cycle as the final `hit_pulse` or `miss_pulse`. `busy` falls in that same cycle.
- `hit_pulse` and `miss_pulse` are never high together.

## Structure
- Shared package `rhythm_pkg`:
  - `SCORE_W`=5, matching the `winner` inputs.
  - Score saturation constant 31.
  - State encoding constants IDLE=0, WAIT_NOTE=1, WINDOW=2, DONE=3.
- Counter widths: `$clog2(WINDOW_CYCLES+1)` and `$clog2(NOTES_PER_ROUND+1)`.
- One sub-module: `btn_edge`, which contains the `btn_q` register and the rising-edge detect. It has the same synchronous active-low reset. Everything else stays in the top level.

## Test plan
- Reset mid-round: 3 hits, then `reset`=0 for one edge → the next cycle shows `result`=0, `busy`=0, `round_done`=0, with no pulses.
- Basic round, `NOTES_PER_ROUND`=4, `WINDOW_CYCLES`=8: presses at T+1 and T+8 on notes 1–2, no press on notes 3–4 → 2 `hit_pulse`s, 2 `miss_pulse`s, final `result`=2, `round_done`=1.
- Window edges, single note: a press at T gives `miss_pulse` after edge T+8 and no hit. A press at T+9 gives a miss and the press is ignored. A held button across two notes scores only the first.
- Overlapping notes: second `note_strobe` at T+3 with no press → `miss_pulse` in the cycle after T+3, and a fresh 8-cycle window for the second note. Repeat with a press at T+3 → a hit for the first note only.
- Saturation: `NOTES_PER_ROUND`=31, all hits, then `start` and 31 hits again → `result`=31 at the end of each round. The second `start` clears `result` to 0 in the cycle after it is sampled.
- Ignored inputs: `start` during WINDOW and presses in WAIT_NOTE, IDLE and DONE → no state change and no pulses.
